// File: rtl/avalon_pio_pkg.sv
// Shared register map, edge-mode encodings and address type for the edge-capturing PIO.
package avalon_pio_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA    = 3'd0;
    localparam addr_t ADDR_OUTSET  = 3'd1;
    localparam addr_t ADDR_OUTCLR  = 3'd2;
    localparam addr_t ADDR_IRQMASK = 3'd3;
    localparam addr_t ADDR_EDGECAP = 3'd4;
    localparam addr_t ADDR_OUTRD   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, one-cycle history and edge detector, gated until the chain has flushed.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] ev_o
);

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       arm_cnt_q;
    logic             armed;
    logic [WIDTH-1:0] edge_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q[0] <= in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 3'd1;
            end
        end
    end

    // Edges seen while the chain still carries reset zeros are artefacts, not pin activity.
    assign armed  = (arm_cnt_q == ARM_MAX);
    assign sync_o = sync_q[SYNC_STAGES-1];

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            EDGE_FALL: edge_raw = ~sync_o & prev_q;
            EDGE_ANY:  edge_raw = sync_o ^ prev_q;
            default:   edge_raw = sync_o & ~prev_q;
        endcase
    end

    assign ev_o = armed ? edge_raw : '0;

endmodule

// File: rtl/avalon_pio_edge.sv
// Avalon-MM PIO slave: output register with set/clear, synchronised inputs, edge capture and masked irq.
module avalon_pio_edge
    import avalon_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_OUT = RESET_VALUE[WIDTH-1:0];

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;

    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic [WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [WIDTH-1:0] edgecap_q,  edgecap_d;
    logic             irq_q,      irq_d;
    logic [31:0]      readdata_q, readdata_d;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (in_port),
        .sync_o  (sync_in),
        .ev_o    (ev)
    );

    always_comb begin
        out_port_d = out_port_q;
        irqmask_d  = irqmask_q;
        clr        = '0;
        if (wr) begin
            case (addr_t'(address))
                ADDR_DATA:    out_port_d = wd;
                ADDR_OUTSET:  out_port_d = out_port_q | wd;
                ADDR_OUTCLR:  out_port_d = out_port_q & ~wd;
                ADDR_IRQMASK: irqmask_d  = wd;
                ADDR_EDGECAP: clr        = wd;
                default:      ;
            endcase
        end
        // A new edge overrides a simultaneous clear of the same bit.
        edgecap_d = (edgecap_q & ~clr) | ev;
        irq_d     = |(edgecap_d & irqmask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (addr_t'(address))
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_in;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            ADDR_OUTRD:   readdata_d[WIDTH-1:0] = out_port_q;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port_q <= RST_OUT;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            out_port_q <= out_port_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_port_q;
    assign irq      = irq_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_avalon_pio_edge.sv
// Directed bench: an 8-bit rising-edge instance and a 4-bit any-edge instance on a shared bus.
module tb_avalon_pio_edge;
    import avalon_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs8, cs4;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata8, readdata4;
    logic [7:0]  in8, out8;
    logic [3:0]  in4, out4;
    logic        irq8, irq4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_pio_edge #(
        .WIDTH(8), .RESET_VALUE(32'h5A), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
        .write_n(write_n), .writedata(writedata), .readdata(readdata8),
        .in_port(in8), .out_port(out8), .irq(irq8)
    );

    avalon_pio_edge #(
        .WIDTH(4), .RESET_VALUE(32'h9), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(3)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
        .write_n(write_n), .writedata(writedata), .readdata(readdata4),
        .in_port(in4), .out_port(out4), .irq(irq4)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit sel4, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        if (sel4) cs4 = 1'b1;
        else      cs8 = 1'b1;
        tick();
        cs8     = 1'b0;
        cs4     = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in8 = 8'hFF;
        in4 = 4'hF;
        tick(3);
        checks++; if (out8 !== 8'h5A) begin errors++; $display("FAIL reset_out8 got=%h exp=5a", out8); end
        checks++; if (out4 !== 4'h9) begin errors++; $display("FAIL reset_out4 got=%h exp=9", out4); end
        checks++; if (readdata8 !== 32'd0 || irq8 !== 1'b0) begin errors++; $display("FAIL reset_rd_irq8 rd=%h irq=%b exp 0/0", readdata8, irq8); end
        reset_n = 1'b1;
        tick(4);
        rd(ADDR_DATA);
        checks++; if (readdata8 !== 32'hFF) begin errors++; $display("FAIL data8 got=%h exp=ff", readdata8); end
        checks++; if (readdata4 !== 32'hF) begin errors++; $display("FAIL data4 got=%h exp=f", readdata4); end
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'd0) begin errors++; $display("FAIL nocap8 got=%h exp=0", readdata8); end
        checks++; if (readdata4 !== 32'd0) begin errors++; $display("FAIL nocap4 got=%h exp=0", readdata4); end
        checks++; if (irq8 !== 1'b0 || irq4 !== 1'b0) begin errors++; $display("FAIL irq_after_reset got=%b%b exp=00", irq8, irq4); end
        rd(ADDR_OUTRD);
        checks++; if (readdata8 !== 32'h5A || readdata4 !== 32'h9) begin errors++; $display("FAIL outrd_reset got=%h/%h exp=5a/9", readdata8, readdata4); end
    endtask

    task automatic test_set_clr();
        wr(0, ADDR_DATA, 32'hA5);
        checks++; if (out8 !== 8'hA5) begin errors++; $display("FAIL data_wr got=%h exp=a5", out8); end
        wr(0, ADDR_OUTSET, 32'h0A);
        checks++; if (out8 !== 8'hAF) begin errors++; $display("FAIL outset got=%h exp=af", out8); end
        wr(0, ADDR_OUTCLR, 32'h81);
        checks++; if (out8 !== 8'h2E) begin errors++; $display("FAIL outclr got=%h exp=2e", out8); end
        rd(ADDR_OUTRD);
        checks++; if (readdata8 !== 32'h2E) begin errors++; $display("FAIL outrd got=%h exp=2e", readdata8); end
        rd(ADDR_OUTSET);
        checks++; if (readdata8 !== 32'd0) begin errors++; $display("FAIL outset_rd got=%h exp=0", readdata8); end
        checks++; if (out4 !== 4'h9) begin errors++; $display("FAIL out4_untouched got=%h exp=9", out4); end
    endtask

    task automatic test_edge_irq();
        wr(0, ADDR_IRQMASK, 32'h04);
        in8 = 8'hFB;
        tick(5);
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'd0) begin errors++; $display("FAIL fall_nocap got=%h exp=0", readdata8); end
        in8 = 8'hFF;
        tick(2);
        checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq8); end
        tick();
        checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq8); end
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'h04) begin errors++; $display("FAIL cap_rise got=%h exp=04", readdata8); end
        in8 = 8'hFB;
        tick(5);
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'h04 || irq8 !== 1'b1) begin errors++; $display("FAIL fall_hold got=%h irq=%b exp=04/1", readdata8, irq8); end
        wr(0, ADDR_EDGECAP, 32'h04);
        checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL irq_clr got=%b exp=0", irq8); end
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'd0) begin errors++; $display("FAIL cap_clr got=%h exp=0", readdata8); end
    endtask

    task automatic test_collision();
        in8 = 8'hF3;
        tick(5);
        in8 = 8'hFB;
        tick(5);
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'h08) begin errors++; $display("FAIL cap_bit3 got=%h exp=08", readdata8); end
        in8 = 8'hF3;
        tick(5);
        in8 = 8'hFB;
        tick(2);
        wr(0, ADDR_EDGECAP, 32'h08);
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'h08) begin errors++; $display("FAIL collision got=%h exp=08", readdata8); end
        wr(0, ADDR_EDGECAP, 32'h08);
        rd(ADDR_EDGECAP);
        checks++; if (readdata8 !== 32'd0) begin errors++; $display("FAIL clr_bit3 got=%h exp=0", readdata8); end
        checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL irq_masked8 got=%b exp=0", irq8); end
    endtask

    task automatic test_width_mask();
        wr(1, ADDR_DATA, 32'hFFFF_FFFF);
        checks++; if (out4 !== 4'hF) begin errors++; $display("FAIL width_out got=%h exp=f", out4); end
        rd(ADDR_OUTRD);
        checks++; if (readdata4 !== 32'h0000_000F) begin errors++; $display("FAIL width_outrd got=%h exp=0000000f", readdata4); end
        checks++; if (readdata8 !== 32'h2E) begin errors++; $display("FAIL out8_untouched got=%h exp=2e", readdata8); end
        in4 = 4'hE;
        tick(6);
        rd(ADDR_EDGECAP);
        checks++; if (readdata4 !== 32'h1) begin errors++; $display("FAIL any_fall got=%h exp=1", readdata4); end
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_nomask got=%b exp=0", irq4); end
        wr(1, ADDR_IRQMASK, 32'h1);
        tick();
        checks++; if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_mask_set got=%b exp=1", irq4); end
    endtask

    task automatic test_mid_reset();
        in4 = 4'h1;
        tick(6);
        rd(ADDR_EDGECAP);
        checks++; if (readdata4 !== 32'hF) begin errors++; $display("FAIL pre_rst_cap got=%h exp=f", readdata4); end
        wr(1, ADDR_OUTCLR, 32'hC);
        checks++; if (out4 !== 4'h3) begin errors++; $display("FAIL pre_rst_out got=%h exp=3", out4); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out4 !== 4'h9 || irq4 !== 1'b0 || readdata4 !== 32'd0) begin errors++; $display("FAIL async_rst4 out=%h irq=%b rd=%h exp=9/0/0", out4, irq4, readdata4); end
        checks++; if (out8 !== 8'h5A || irq8 !== 1'b0 || readdata8 !== 32'd0) begin errors++; $display("FAIL async_rst8 out=%h irq=%b rd=%h exp=5a/0/0", out8, irq8, readdata8); end
        address = ADDR_EDGECAP;
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (readdata4 !== 32'd0 || irq4 !== 1'b0) begin errors++; $display("FAIL rearm_nocap cyc=%0d got=%h irq=%b exp=0/0", i, readdata4, irq4); end
        end
        in4 = 4'h0;
        tick(7);
        checks++; if (readdata4 !== 32'h1) begin errors++; $display("FAIL rearm_cap got=%h exp=1", readdata4); end
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = ADDR_DATA;
        cs8       = 1'b0;
        cs4       = 1'b0;
        write_n   = 1'b1;
        writedata = 32'd0;
        in8       = 8'h00;
        in4       = 4'h0;
        test_reset();
        test_set_clr();
        test_edge_irq();
        test_collision();
        test_width_mask();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
